// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sequential stimulus/response stage that walks every input
// vector of an N_IN-input combinational function in ascending order, holds each
// vector SETTLE+1 cycles, samples the function output into a truth table and
// compares that table against an expected minterm mask.
//
// Parameters:
//   N_IN    number of function inputs (vec width); table width is 2**N_IN
//   SETTLE  extra hold cycles per vector before sampling (0..15)
//   EXPECT  expected truth table, bit i = f(vec=i)
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         scan request, accepted only when idle
//   s_in          output of the function under test
//   vec           current input vector (MSB = x, LSB = z for N_IN = 3)
//   busy          high while a scan is running
//   done          one-cycle pulse when a scan completes
//   table_out     captured truth table, bit i = s_in sampled for vec = i
//   match         table_out == EXPECT, valid from done onward
//   mismatch_cnt  number of table bits that differ from EXPECT
//
// Build option: define TT_STOP_ON_FAIL_EN to end the scan at the first sample
// that disagrees with EXPECT (vec then holds the failing index).

module truth_table_scanner #(
  parameter int unsigned        N_IN   = 3,
  parameter int unsigned        SETTLE = 1,
  parameter logic [2**N_IN-1:0] EXPECT = 8'b1110_0100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 s_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 match,
  output logic [N_IN:0]        mismatch_cnt
);

  localparam logic [N_IN-1:0] LastVec = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VecOne  = 1;
  localparam logic [N_IN:0]   MisOne  = 1;
  localparam logic [3:0]      Reload  = 4'(SETTLE);

  typedef enum logic [1:0] {StIdle, StHold, StSample, StFin} state_e;

  // With no settle time a vector is sampled on the very next edge.
  localparam state_e StFirst = (SETTLE == 0) ? StSample : StHold;

  state_e                state_q, state_d;
  logic [N_IN-1:0]       vec_q, vec_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2**N_IN-1:0]    table_q, table_d;
  logic [N_IN:0]         mis_q, mis_d;
  logic                  match_q, match_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_fail;
  logic                  finish;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    table_d  = table_q;
    mis_d    = mis_q;
    match_d  = match_q;
    busy_d   = busy_q;
    done_d   = done_q;
    bit_fail = 1'b0;
    finish   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          vec_d   = '0;
          table_d = '0;
          mis_d   = '0;
          match_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = Reload;
          state_d = StFirst;
        end
      end

      StHold: begin
        cnt_d = cnt_q - 4'd1;
        // Counter reaches zero on this edge, so the next edge samples.
        if (cnt_q <= 4'd1) begin
          state_d = StSample;
        end
      end

      StSample: begin
        table_d[vec_q] = s_in;
        bit_fail       = (s_in != EXPECT[vec_q]);
        if (bit_fail) begin
          mis_d = mis_q + MisOne;
        end
`ifdef TT_STOP_ON_FAIL_EN
        finish = bit_fail || (vec_q == LastVec);
`else
        finish = (vec_q == LastVec);
`endif
        if (finish) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (table_d == EXPECT);
          state_d = StFin;
        end else begin
          vec_d   = vec_q + VecOne;
          cnt_d   = Reload;
          state_d = StFirst;
        end
      end

      StFin: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      mis_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      mis_q   <= mis_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vec          = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign match        = match_q;
  assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  localparam logic [7:0] EXP = 8'hE4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic s_in  = 1'b0;
  logic sel   = 1'b0;  // 0: SETTLE=1 instance, 1: SETTLE=0 instance

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic       start_a, start_b;
  logic [2:0] vec_a, vec_b, o_vec;
  logic       busy_a, busy_b, o_busy;
  logic       done_a, done_b, o_done;
  logic [7:0] tab_a, tab_b, o_tab;
  logic       match_a, match_b, o_match;
  logic [3:0] mis_a, mis_b, o_mis;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign o_vec   = sel ? vec_b   : vec_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_tab   = sel ? tab_b   : tab_a;
  assign o_match = sel ? match_b : match_a;
  assign o_mis   = sel ? mis_b   : mis_a;

  truth_table_scanner #(.N_IN(3), .SETTLE(1), .EXPECT(EXP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_a),
    .s_in         (s_in),
    .vec          (vec_a),
    .busy         (busy_a),
    .done         (done_a),
    .table_out    (tab_a),
    .match        (match_a),
    .mismatch_cnt (mis_a)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(0), .EXPECT(EXP)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_b),
    .s_in         (s_in),
    .vec          (vec_b),
    .busy         (busy_b),
    .done         (done_b),
    .table_out    (tab_b),
    .match        (match_b),
    .mismatch_cnt (mis_b)
  );

  // Index of the last vector a scan of this pattern visits.
  function automatic int model_last(input logic [7:0] pat);
`ifdef TT_STOP_ON_FAIL_EN
    for (int k = 0; k < 8; k++) begin
      if (pat[k] != EXP[k]) return k;
    end
`endif
    return 7;
  endfunction

  // One full scan: start at edge 0, s_in follows pat on sample edges and is
  // random in between; every edge checks vec/busy/done against the model.
  task automatic run_scan(input bit s0, input logic [7:0] pat, input bit repulse);
    int         per;
    int         last;
    int         d;
    int         exp_vec;
    int         exp_mis;
    int         idx;
    logic [7:0] exp_tab;
    logic       exp_match;
    per     = s0 ? 1 : 2;
    last    = model_last(pat);
    d       = (last + 1) * per;
    exp_tab = 8'h00;
    exp_mis = 0;
    for (int k = 0; k <= last; k++) begin
      exp_tab[k] = pat[k];
      if (pat[k] != EXP[k]) exp_mis++;
    end
    exp_match = (exp_tab == EXP);
    sel = s0;
    for (int i = 0; i <= d + 1; i++) begin
      start = (i == 0) || (repulse && (i == 5 || i == 9));
      idx   = i / per - 1;
      if (i > 0 && (i % per) == 0 && idx <= 7) s_in = pat[idx];
      else s_in = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      exp_vec = (i < d) ? i / per : last;
      n_tests++;
      if (o_vec !== 3'(exp_vec)) begin
        n_fail++;
        $display("FAIL scan_vec s0=%0d pat=%h edge=%0d got=%0d want=%0d",
                 s0, pat, i, o_vec, exp_vec);
      end
      n_tests++;
      if (o_busy !== (i < d)) begin
        n_fail++;
        $display("FAIL scan_busy s0=%0d pat=%h edge=%0d got=%b want=%b",
                 s0, pat, i, o_busy, (i < d));
      end
      n_tests++;
      if (o_done !== (i == d)) begin
        n_fail++;
        $display("FAIL scan_done s0=%0d pat=%h edge=%0d got=%b want=%b",
                 s0, pat, i, o_done, (i == d));
      end
      if (i >= d) begin
        n_tests++;
        if (o_tab !== exp_tab) begin
          n_fail++;
          $display("FAIL scan_table s0=%0d pat=%h edge=%0d got=%h want=%h",
                   s0, pat, i, o_tab, exp_tab);
        end
        n_tests++;
        if (o_match !== exp_match) begin
          n_fail++;
          $display("FAIL scan_match s0=%0d pat=%h edge=%0d got=%b want=%b",
                   s0, pat, i, o_match, exp_match);
        end
        n_tests++;
        if (o_mis !== 4'(exp_mis)) begin
          n_fail++;
          $display("FAIL scan_mismatch s0=%0d pat=%h edge=%0d got=%0d want=%0d",
                   s0, pat, i, o_mis, exp_mis);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({o_vec, o_busy, o_done, o_tab, o_match, o_mis} !== 18'h0) begin
      n_fail++;
      $display("FAIL %s sel=%0d got vec=%0d busy=%b done=%b tab=%h match=%b mis=%0d want all 0",
               name, sel, o_vec, o_busy, o_done, o_tab, o_match, o_mis);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    sel = 1'b0;
    #1 check_zero("reset_a");
    sel = 1'b1;
    #1 check_zero("reset_b");
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 1'b0;
  endtask

  task automatic test_patterns();
    logic [7:0] r;
    run_scan(1'b0, EXP, 1'b0);
    run_scan(1'b0, 8'h00, 1'b0);
    run_scan(1'b0, 8'h1B, 1'b0);
    run_scan(1'b1, EXP, 1'b0);
    run_scan(1'b1, 8'h1B, 1'b0);
    for (int n = 0; n < 4; n++) begin
      r = 8'($urandom);
      run_scan(1'b0, r, 1'b0);
      r = 8'($urandom);
      run_scan(1'b1, r, 1'b0);
    end
  endtask

  task automatic test_restart_ignored();
    run_scan(1'b0, EXP, 1'b1);
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      start = (i == 0);
      s_in  = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    n_tests++;
    if (o_vec !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_reset_pre got vec=%0d want 3", o_vec);
    end
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1'b0, EXP, 1'b0);
  endtask

  task automatic test_back_to_back();
    int d;
    sel = 1'b0;
    d   = (model_last(EXP) + 1) * 2;
    start = 1'b1;
    for (int i = 0; i <= d + 2; i++) begin
      s_in = EXP[(i / 2 + 7) % 8];
      @(posedge clk);
      @(negedge clk);
      if (i == d + 1) begin
        n_tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_gap got busy=%b done=%b want 0 0", o_busy, o_done);
        end
      end
      if (i == d + 2) begin
        n_tests++;
        if (o_busy !== 1'b1 || o_vec !== 3'd0 || o_tab !== 8'h00) begin
          n_fail++;
          $display("FAIL b2b_restart got busy=%b vec=%0d tab=%h want 1 0 00",
                   o_busy, o_vec, o_tab);
        end
      end
    end
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    run_scan(1'b0, EXP, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus and response stage that wraps a 3-input combinational function block such as fxy.
- Drives every input vector {x,y,z} in ascending order and waits a settle time for each one.
- Captures the function output into a truth-table register and compares the table against an expected minterm mask.
- Replaces hand-written #1 stepping benches with a reusable, synthesizable checker.

Parameters:
- N_IN, 3, number of function inputs; vec width; table width is 2**N_IN.
- SETTLE, 1, extra cycles each vector is held before sampling; each vector is held SETTLE+1 cycles; range 0..15.
- EXPECT, 8'b1110_0100, expected truth table; bit i is f(vec=i). The default is minterms 2,5,6,7.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request; accepted only in IDLE.
- s_in  input  1  output of the function under test.
- vec  output  N_IN  current input vector; MSB=x, LSB=z for N_IN=3.
- busy  output  1  high while a scan is running.
- done  output  1  one-cycle pulse when a scan completes.
- table_out  output  2**N_IN  captured truth table; bit i = s_in sampled for vec=i.
- match  output  1  table_out==EXPECT; valid from done onward.
- mismatch_cnt  output  N_IN+1  number of bit positions where table_out differs from EXPECT.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. vec, busy, done, table_out, match and mismatch_cnt all 0. Reset mid-scan discards the partial table.
- FSM states: IDLE, HOLD, SAMPLE, FIN.
- IDLE, start=1 at edge E0: vec<=0, table_out<=0, mismatch_cnt<=0, match<=0, busy<=1, hold counter<=SETTLE, go to HOLD. With SETTLE=0, go directly to SAMPLE.
- HOLD: decrement the hold counter each cycle; go to SAMPLE when it reaches 0. vec is stable throughout.
- SAMPLE edge:
  - table_out[vec]<=s_in.
  - mismatch_cnt increments if s_in!=EXPECT[vec].
  - If vec==2**N_IN-1, go to FIN. Otherwise vec<=vec+1, reload the counter, go to HOLD.
- Timing: vector k is visible from edge E(k*(SETTLE+1)) and is sampled at edge E((k+1)*(SETTLE+1)).
- Latency and FIN:
  - The last sample edge E(2**N_IN*(SETTLE+1)) also sets busy<=0, done<=1 and match<=(final table==EXPECT).
  - The FSM is in FIN for exactly one cycle. At the next edge done<=0 and the FSM returns to IDLE.
  - Defaults: done is high between E16 and E17.
- vec after the scan: holds 2**N_IN-1 until the next start. It does not wrap to 0; wrap is suppressed.
- Result hold: table_out, match and mismatch_cnt hold until the next accepted start.
- start while busy or in FIN: ignored, no restart, no effect on the scan.
- start held high continuously: a new scan begins on the first IDLE cycle after FIN.
- Simultaneous reset and start: reset wins.
- s_in is registered only on SAMPLE edges. Glitches during HOLD have no effect.
- Arithmetic: the mismatch counter is N_IN+1 bits, so 2**N_IN mismatches fit without overflow.

Optional Feature:
- Macro: TT_STOP_ON_FAIL_EN.
- Defined:
  - On the first SAMPLE edge where s_in!=EXPECT[vec], the FSM goes straight to FIN. busy<=0, done<=1, match<=0, mismatch_cnt=1.
  - vec holds the failing index until the next start.
  - table_out bits above the failing index remain 0.
- Undefined: the full table is always scanned; the behaviour is as above.

Test Plan:
- Defaults, s_in driven by fxy(vec), start pulse at E0 -> vec steps 0..7 every 2 cycles; done high for exactly one cycle at E16; table_out=8'hE4, match=1, mismatch_cnt=0, busy low after E16.
- s_in tied 0 -> table_out=8'h00, match=0, mismatch_cnt=4. s_in = inverted fxy -> table_out=8'h1B, mismatch_cnt=8.
- rst_n pulsed low while vec=3 -> all outputs 0 immediately (asynchronous); then start -> full scan gives 8'hE4 with done at the expected latency.
- start re-pulsed at E5 and E9 during a scan -> ignored; single done at E16; table correct.
- SETTLE=0 with fxy -> vec changes every cycle; done at E8; table_out=8'hE4.
- TT_STOP_ON_FAIL_EN defined, s_in = inverted fxy -> done at E2; vec=0, mismatch_cnt=1, match=0, table_out=8'h01.
